// File: rtl/ddr2_local_arb_pkg.sv
// ddr2_local_arb_pkg: shared types and constants for the DDR2 local-interface arbiter
// Contents: arbiter FSM state enum, grant enum, largest legal local burst size.
package ddr2_local_arb_pkg;
  typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD} arb_state_t;
  typedef enum logic {GNT_WR, GNT_RD} arb_gnt_t;
  localparam int MAX_LOCAL_SIZE = 4;
endpackage

// File: rtl/ddr2_local_rd_tracker.sv
// ddr2_local_rd_tracker: outstanding read-beat counter, read credit check and registered read return
// Ports: clk/reset; i_req_size = clamped size of the pending read request (credit check);
//        i_acc/i_acc_size = read command accepted and its latched size;
//        i_rdata/i_rdata_valid = controller read return; o_credit_ok = request fits;
//        o_rd_out = beats in flight; o_rd_data/o_rd_data_valid = registered return to client.
module ddr2_local_rd_tracker
  import ddr2_local_arb_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int SIZE_W       = 3,
  parameter int MAX_RD_BEATS = 8,
  parameter int CNT_W        = $clog2(MAX_RD_BEATS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SIZE_W-1:0] i_req_size,
  input  logic              i_acc,
  input  logic [SIZE_W-1:0] i_acc_size,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic              i_rdata_valid,
  output logic              o_credit_ok,
  output logic [CNT_W-1:0]  o_rd_out,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_data_valid
);
  localparam int SUM_W = CNT_W + SIZE_W;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic [SUM_W-1:0]  w_need, w_sum, w_next;
  always_comb begin
    w_need      = SUM_W'(r_cnt) + SUM_W'(i_req_size);
    o_credit_ok = w_need <= SUM_W'(MAX_RD_BEATS);
    w_sum       = SUM_W'(r_cnt) + (i_acc ? SUM_W'(i_acc_size) : '0);
    // a return with nothing in flight is forwarded but must not wrap the counter
    w_next      = (i_rdata_valid && w_sum != '0) ? w_sum - SUM_W'(1) : w_sum;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_cnt      <= CNT_W'(w_next);
      r_rd_data  <= i_rdata_valid ? i_rdata : r_rd_data;
      r_rd_valid <= i_rdata_valid;
    end
  assign o_rd_out        = r_cnt;
  assign o_rd_data       = r_rd_data;
  assign o_rd_data_valid = r_rd_valid;
endmodule

// File: rtl/ddr2_local_arbiter.sv
// ddr2_local_arbiter: merges a write client and a read client onto the DDR2 native local interface
// Config macro: DDR2_LOCAL_ARB_RD_PRIO_EN -> reads win every tie (no round-robin state);
//               undefined -> round-robin, first tie after reset goes to write.
// Ports: clk/reset (async, active-high); local_init_done gates grants;
//        wr_req/wr_addr/wr_size/wr_data/wr_be/wr_ack = write client, one ack per beat;
//        rd_req/rd_addr/rd_size/rd_ack = read command client; rd_data/rd_data_valid = read return;
//        local_* = controller command, write data and read return; busy = not idle or reads in flight.
module ddr2_local_arbiter
  import ddr2_local_arb_pkg::*;
#(
  parameter int ADDR_W       = 25,
  parameter int DATA_W       = 64,
  parameter int BE_W         = 8,
  parameter int SIZE_W       = 3,
  parameter int MAX_RD_BEATS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              local_init_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [SIZE_W-1:0] wr_size,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [SIZE_W-1:0] rd_size,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic [ADDR_W-1:0] local_address,
  output logic [SIZE_W-1:0] local_size,
  output logic              local_burstbegin,
  output logic              local_write_req,
  output logic              local_read_req,
  output logic [DATA_W-1:0] local_wdata,
  output logic [BE_W-1:0]   local_be,
  input  logic              local_ready,
  input  logic [DATA_W-1:0] local_rdata,
  input  logic              local_rdata_valid,
  output logic              busy
);
  localparam int CNT_W = $clog2(MAX_RD_BEATS + 1);
  arb_state_t        r_state, w_state_nx;
  logic [ADDR_W-1:0] r_addr;
  logic [SIZE_W-1:0] r_size, r_beat, w_wr_size, w_rd_size;
  logic              w_rd_ok, w_gnt, w_gnt_rd, w_wr_acc, w_rd_acc, w_wr_last;
  logic [CNT_W-1:0]  w_rd_out;
`ifndef DDR2_LOCAL_ARB_RD_PRIO_EN
  arb_gnt_t          r_last;
`endif
  always_comb begin
    // size 0 means a single beat; anything above the controller maximum is clamped
    w_wr_size = wr_size == '0 ? SIZE_W'(1) : wr_size > SIZE_W'(MAX_LOCAL_SIZE) ? SIZE_W'(MAX_LOCAL_SIZE) : wr_size;
    w_rd_size = rd_size == '0 ? SIZE_W'(1) : rd_size > SIZE_W'(MAX_LOCAL_SIZE) ? SIZE_W'(MAX_LOCAL_SIZE) : rd_size;
    w_wr_acc  = r_state == WR_BURST && local_ready;
    w_rd_acc  = r_state == RD_CMD && local_ready;
    w_wr_last = w_wr_acc && r_beat == r_size - SIZE_W'(1);
    w_gnt     = r_state == IDLE && local_init_done && (wr_req || (rd_req && w_rd_ok));
`ifdef DDR2_LOCAL_ARB_RD_PRIO_EN
    w_gnt_rd  = w_gnt && rd_req && w_rd_ok;
`else
    w_gnt_rd  = w_gnt && rd_req && w_rd_ok && (!wr_req || r_last == GNT_WR);
`endif
    w_state_nx = w_gnt ? (w_gnt_rd ? RD_CMD : WR_BURST) : (w_wr_last || w_rd_acc) ? IDLE : r_state;
    local_write_req  = r_state == WR_BURST;
    local_read_req   = r_state == RD_CMD;
    // burstbegin marks only the first beat of a write, and a read until it is taken
    local_burstbegin = local_read_req || (local_write_req && r_beat == '0);
    local_wdata      = local_write_req ? wr_data : '0;
    local_be         = local_write_req ? wr_be : '0;
    wr_ack           = w_wr_acc;
    rd_ack           = w_rd_acc;
    local_address    = r_addr;
    local_size       = r_size;
    busy             = r_state != IDLE || w_rd_out != '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_size  <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_beat  <= w_gnt ? '0 : w_wr_acc ? r_beat + SIZE_W'(1) : r_beat;
      if (w_gnt) begin
        r_addr <= w_gnt_rd ? rd_addr : wr_addr;
        r_size <= w_gnt_rd ? w_rd_size : w_wr_size;
      end
    end
`ifndef DDR2_LOCAL_ARB_RD_PRIO_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) r_last <= GNT_RD;
    else if (w_gnt) r_last <= w_gnt_rd ? GNT_RD : GNT_WR;
`endif
  ddr2_local_rd_tracker #(
    .DATA_W(DATA_W), .SIZE_W(SIZE_W), .MAX_RD_BEATS(MAX_RD_BEATS), .CNT_W(CNT_W)
  ) u_rd_trk (
    .clk(clk),
    .reset(reset),
    .i_req_size(w_rd_size),
    .i_acc(w_rd_acc),
    .i_acc_size(r_size),
    .i_rdata(local_rdata),
    .i_rdata_valid(local_rdata_valid),
    .o_credit_ok(w_rd_ok),
    .o_rd_out(w_rd_out),
    .o_rd_data(rd_data),
    .o_rd_data_valid(rd_data_valid)
  );
endmodule

// File: tb/tb_ddr2_local_arbiter.sv
// tb_ddr2_local_arbiter: randomized scenario bench for ddr2_local_arbiter against a transaction-level model
module tb_ddr2_local_arbiter;
  logic        clk = 0, reset = 1, local_init_done = 0, wr_req = 0, rd_req = 0;
  logic        local_ready = 0, local_rdata_valid = 0;
  logic [24:0] wr_addr = '0, rd_addr = '0, local_address;
  logic [2:0]  wr_size = '0, rd_size = '0, local_size;
  logic [63:0] wr_data = '0, local_rdata = '0, rd_data, local_wdata;
  logic [7:0]  wr_be = '0, local_be;
  logic        wr_ack, rd_ack, rd_data_valid, local_burstbegin, local_write_req, local_read_req, busy;
  int          n_chk = 0, n_pass = 0;
  int          m_rd_out = 0;
  int          m_last = 1;
  bit          prio = 0;

  ddr2_local_arbiter dut (
    .clk(clk), .reset(reset), .local_init_done(local_init_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size), .wr_data(wr_data), .wr_be(wr_be), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_size(rd_size), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .local_address(local_address), .local_size(local_size), .local_burstbegin(local_burstbegin),
    .local_write_req(local_write_req), .local_read_req(local_read_req),
    .local_wdata(local_wdata), .local_be(local_be), .local_ready(local_ready),
    .local_rdata(local_rdata), .local_rdata_valid(local_rdata_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input int s);
    return s == 0 ? 1 : (s > 4 ? 4 : s);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ret_one;
    logic [63:0] d;
    d = {$urandom, $urandom};
    local_rdata_valid = 1;
    local_rdata = d;
    tick;
    local_rdata_valid = 0;
    if (m_rd_out > 0) m_rd_out--;
    #1;
    n_chk++;
    if ({rd_data_valid, rd_data, busy} !== {1'b1, d, m_rd_out != 0})
      $display("FAIL rd_return: got v/data/busy=%h required %h", {rd_data_valid, rd_data, busy}, {1'b1, d, m_rd_out != 0});
    else n_pass++;
  endtask

  task automatic drain;
    while (m_rd_out > 0) ret_one;
  endtask

  task automatic do_write(input logic [24:0] a, input logic [2:0] s, input int stall_beat, input int stall_len, input bit rnd);
    logic [63:0] d[4];
    logic [7:0]  b[4];
    int n, beat, stall, guard, acks;
    n = clamp(int'(s));
    for (int i = 0; i < 4; i++) begin
      d[i] = {$urandom, $urandom};
      b[i] = 8'($urandom);
    end
    wr_req = 1; wr_addr = a; wr_size = s;
    beat = 0; stall = 0; guard = 0; acks = 0;
    while (beat < n && guard < 100) begin
      wr_data = d[beat]; wr_be = b[beat];
      local_ready = rnd ? ($urandom_range(0, 3) != 0) : !(beat == stall_beat && stall < stall_len);
      #1;
      if (local_write_req) begin
        n_chk++;
        if ({local_burstbegin, local_address, local_size, local_wdata, local_be, wr_ack} !==
            {beat == 0, a, 3'(n), d[beat], b[beat], local_ready})
          $display("FAIL wr_beat%0d: got bb/addr/size/data/be/ack=%h required %h", beat,
                   {local_burstbegin, local_address, local_size, local_wdata, local_be, wr_ack},
                   {beat == 0, a, 3'(n), d[beat], b[beat], local_ready});
        else n_pass++;
        acks += int'(wr_ack);
        if (local_ready) beat++;
        else if (beat == stall_beat) stall++;
      end
      tick;
      guard++;
    end
    wr_req = 0; local_ready = 1;
    m_last = 0;
    n_chk++;
    if (guard >= 100) $display("FAIL wr_timeout: got %0d of %0d beats", beat, n);
    else n_pass++;
    #1;
    n_chk++;
    if ({acks, local_write_req, wr_ack, busy} !== {n, 1'b0, 1'b0, m_rd_out != 0})
      $display("FAIL wr_end: got acks/req/ack/busy=%h required %h", {acks, local_write_req, wr_ack, busy}, {n, 1'b0, 1'b0, m_rd_out != 0});
    else n_pass++;
  endtask

  task automatic do_read(input logic [24:0] a, input logic [2:0] s, input bit ret_same, input bit rnd);
    logic [63:0] d;
    int n, guard;
    bit done;
    n = clamp(int'(s));
    d = {$urandom, $urandom};
    rd_req = 1; rd_addr = a; rd_size = s;
    guard = 0; done = 0;
    while (!done && guard < 100) begin
      local_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      local_rdata_valid = 0;
      #1;
      if (local_read_req) begin
        n_chk++;
        if ({local_burstbegin, local_address, local_size, rd_ack} !== {1'b1, a, 3'(n), local_ready})
          $display("FAIL rd_cmd: got bb/addr/size/ack=%h required %h",
                   {local_burstbegin, local_address, local_size, rd_ack}, {1'b1, a, 3'(n), local_ready});
        else n_pass++;
        if (local_ready) begin
          done = 1;
          if (ret_same) begin
            local_rdata_valid = 1;
            local_rdata = d;
          end
        end
      end
      tick;
      guard++;
    end
    rd_req = 0; local_rdata_valid = 0; local_ready = 1;
    m_last = 1;
    m_rd_out = m_rd_out + n - (ret_same ? 1 : 0);
    n_chk++;
    if (!done) $display("FAIL rd_timeout: got no accept, required accept within 100 cycles");
    else n_pass++;
    #1;
    n_chk++;
    if ({local_read_req, rd_ack, rd_data_valid} !== {1'b0, 1'b0, ret_same} || (ret_same && rd_data !== d))
      $display("FAIL rd_end: got req/ack/v/data=%h required %h", {local_read_req, rd_ack, rd_data_valid, rd_data}, {1'b0, 1'b0, ret_same, d});
    else n_pass++;
  endtask

  task automatic test_reset;
    bit seen;
    reset = 1;
    tick;
    n_chk++;
    if ({wr_ack, rd_ack, rd_data, rd_data_valid, local_address, local_size, local_burstbegin,
         local_write_req, local_read_req, local_wdata, local_be, busy} !== '0)
      $display("FAIL reset_outputs: got %h required 0", {wr_ack, rd_ack, rd_data, rd_data_valid, local_address,
               local_size, local_burstbegin, local_write_req, local_read_req, local_wdata, local_be, busy});
    else n_pass++;
    reset = 0;
    wr_req = 1; wr_addr = 25'h1234; wr_size = 3'd2; rd_req = 1; rd_size = 3'd1;
    seen = 0;
    repeat (5) begin
      #1;
      seen |= local_write_req | local_read_req | busy;
      tick;
    end
    n_chk++;
    if (seen !== 1'b0) $display("FAIL init_done_gate: got grant=%b required 0", seen);
    else n_pass++;
    wr_req = 0; rd_req = 0; local_init_done = 1;
    tick;
  endtask

  task automatic test_write4;
    do_write(25'h0000100, 3'd4, -1, 0, 0);
  endtask

  task automatic test_stall;
    do_write(25'($urandom), 3'd3, 1, 3, 0);
  endtask

  task automatic test_read_credit;
    bit seen;
    do_read(25'($urandom), 3'd4, 0, 0);
    do_read(25'($urandom), 3'd4, 0, 0);
    rd_req = 1; rd_addr = 25'h0abcde; rd_size = 3'd1;
    seen = 0;
    repeat (5) begin
      #1;
      seen |= local_read_req;
      tick;
    end
    n_chk++;
    if (seen !== 1'b0) $display("FAIL rd_credit_block: got grant=%b required 0", seen);
    else n_pass++;
    ret_one;
    do_read(25'h0abcde, 3'd1, 0, 0);
    drain;
  endtask

  task automatic test_simul;
    do_read(25'($urandom), 3'd2, 0, 0);
    do_read(25'($urandom), 3'd2, 1, 0);
    drain;
    ret_one;
  endtask

  task automatic test_clamp;
    do_write(25'($urandom), 3'd0, -1, 0, 0);
    do_write(25'($urandom), 3'd7, -1, 0, 0);
    do_read(25'($urandom), 3'd6, 0, 0);
    do_read(25'($urandom), 3'd0, 0, 0);
    drain;
  endtask

  task automatic test_random;
    int s;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) do_write(25'($urandom), 3'($urandom_range(0, 7)), -1, 0, 1);
      else begin
        s = $urandom_range(0, 7);
        while (m_rd_out + clamp(s) > 8) ret_one;
        do_read(25'($urandom), 3'(s), 1'($urandom_range(0, 1)), 1);
      end
      if ($urandom_range(0, 3) == 0 && m_rd_out > 0) ret_one;
    end
    drain;
  endtask

  task automatic test_reset_mid;
    bit got;
    wr_req = 1; wr_addr = 25'h1f0f0f; wr_size = 3'd4; wr_data = {$urandom, $urandom} | 64'h1; wr_be = 8'hff;
    local_ready = 1;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick;
      got = local_write_req;
    end
    tick;
    reset = 1;
    #1;
    n_chk++;
    if (!got || {wr_ack, rd_ack, rd_data, rd_data_valid, local_address, local_size, local_burstbegin,
         local_write_req, local_read_req, local_wdata, local_be, busy} !== '0)
      $display("FAIL reset_mid: got started=%b outputs=%h required started=1 outputs 0", got, {wr_ack, rd_ack, rd_data,
               rd_data_valid, local_address, local_size, local_burstbegin, local_write_req, local_read_req, local_wdata, local_be, busy});
    else n_pass++;
    tick;
    reset = 0; wr_req = 0;
    m_rd_out = 0; m_last = 1;
    tick;
    n_chk++;
    if ({local_write_req, local_read_req, busy} !== 3'b000)
      $display("FAIL reset_mid_idle: got req/busy=%b required 000", {local_write_req, local_read_req, busy});
    else n_pass++;
  endtask

  task automatic test_rr;
    bit got, exp_rd;
    wr_req = 1; rd_req = 1; wr_size = 3'd1; rd_size = 3'd1;
    wr_addr = 25'($urandom); rd_addr = 25'($urandom); local_ready = 1;
    for (int g = 0; g < 8; g++) begin
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        #1;
        got = local_write_req | local_read_req;
        if (!got) tick;
      end
      exp_rd = (m_rd_out + 1 <= 8) && (prio || m_last == 0);
      n_chk++;
      if (!got || {local_read_req, local_write_req, rd_ack, wr_ack} !== {exp_rd, !exp_rd, exp_rd, !exp_rd})
        $display("FAIL rr_grant%0d: got rd/wr/rdack/wrack=%b required %b", g,
                 {local_read_req, local_write_req, rd_ack, wr_ack}, {exp_rd, !exp_rd, exp_rd, !exp_rd});
      else n_pass++;
      m_last = int'(exp_rd);
      if (exp_rd) m_rd_out++;
      tick;
    end
    wr_req = 0; rd_req = 0;
    tick;
    drain;
  endtask

  initial begin
`ifdef DDR2_LOCAL_ARB_RD_PRIO_EN
    prio = 1;
`endif
    test_reset;
    test_write4;
    test_stall;
    test_read_credit;
    test_simul;
    test_clamp;
    test_random;
    test_reset_mid;
    test_rr;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ddr2_local_arbiter.md
# ddr2_local_arbiter

Two-client arbiter and command sequencer on the DDR2 controller's native local (Avalon-burst) interface, clocked by `phy_clk`. It merges a write client and a read client into one local command stream: it issues `local_burstbegin`, `local_size`, `local_address` and the per-beat write data, honours `local_ready` backpressure, and limits outstanding read beats. It also returns read data to the read client on a registered path.

## Interface
- `ADDR_W`, 25: local word address width.
- `DATA_W`, 64: local data width.
- `BE_W`, 8: byte-enable width, `DATA_W/8`.
- `SIZE_W`, 3: burst size field width; legal sizes 1..4.
- `MAX_RD_BEATS`, 8: maximum outstanding read beats. Counter width is `$clog2(MAX_RD_BEATS+1)`.

Ports:
- `clk` in 1: controller `phy_clk`; all logic is on this single clock.
- `reset` in 1: asynchronous, active-high reset.
- `local_init_done` in 1: no grant is issued while this is low.
- `wr_req` in 1: write burst pending; held until the last beat is acked.
- `wr_addr`, `wr_size` in `ADDR_W`, `SIZE_W`: sampled at grant.
- `wr_data`, `wr_be` in `DATA_W`, `BE_W`: current beat.
- `wr_ack` out 1: beat accepted; present the next beat in the following cycle.
- `rd_req` in 1: read burst pending; `rd_addr`, `rd_size` are valid alongside it.
- `rd_addr`, `rd_size` in `ADDR_W`, `SIZE_W`: read command fields.
- `rd_ack` out 1: read command accepted.
- `rd_data` out `DATA_W`: returned read beat.
- `rd_data_valid` out 1: qualifies `rd_data`.
- `local_address` out `ADDR_W`: to controller.
- `local_size` out `SIZE_W`: to controller.
- `local_burstbegin` out 1: to controller.
- `local_write_req`, `local_read_req` out 1: to controller.
- `local_wdata`, `local_be` out `DATA_W`, `BE_W`: to controller.
- `local_ready` in 1: controller accept.
- `local_rdata` in `DATA_W`: from controller.
- `local_rdata_valid` in 1: from controller.
- `busy` out 1: state is not IDLE or outstanding reads are non-zero.

## Operation
- FSM states: IDLE, WR_BURST, RD_CMD.
- IDLE: a grant is evaluated only when `local_init_done` is high.
  - Eligible clients are `wr_req`, and `rd_req` subject to `rd_out + rd_size <= MAX_RD_BEATS`.
  - With both eligible, round-robin arbitration grants the client not granted last. `last_grant` resets to read, so the first tie goes to write.
  - On grant, the address and size are latched into `local_address`/`local_size`, and the FSM moves to WR_BURST or RD_CMD.
- WR_BURST:
  - `local_write_req` is high every cycle; `local_wdata`/`local_be` are combinational from `wr_data`/`wr_be`.
  - `local_burstbegin` is high only until the first beat is accepted.
  - A beat is accepted when `local_write_req & local_ready`; `wr_ack` equals that term.
  - A beat counter counts up to the latched size; after the last beat the FSM returns to IDLE.
- RD_CMD:
  - `local_read_req` and `local_burstbegin` are held high until `local_ready`.
  - On acceptance, `rd_ack` pulses for one cycle, `rd_out += size`, and the FSM returns to IDLE.
- Read return: each `local_rdata_valid` registers `local_rdata` into `rd_data`, pulses `rd_data_valid`, and decrements `rd_out` by 1.
- Simultaneous read acceptance and return in one cycle: `rd_out += size - 1`.
- Size 0 is treated as 1. Sizes above 4 are clamped to 4.
- A `local_rdata_valid` arriving while `rd_out == 0` is forwarded, and `rd_out` saturates at 0.
- `wr_req` dropping mid-burst is illegal; the block keeps driving `local_write_req`.

## Timing
- Grant to first `local_*_req`: 1 cycle (registered state).
- Back-to-back bursts have one IDLE cycle between them.
- Write beats: 1 per cycle while `local_ready` is high. The minimum burst occupies size+1 cycles including the grant.
- Read data latency: 1 cycle from `local_rdata_valid` to `rd_data_valid`.
- Reset values: FSM=IDLE, `rd_out`=0, and all outputs 0. This includes `local_address`, `local_size`, `rd_data`, `busy` and both acks.
- Reset mid-burst: the burst is abandoned immediately. The controller shares this reset domain, so no recovery sequence is issued.

## Configuration
- `DDR2_LOCAL_ARB_RD_PRIO_EN` defined: fixed priority, with reads winning every tie. `last_grant` is not implemented.
- Macro undefined: round-robin as described in Operation.

## Structure
- Package `ddr2_local_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, WR_BURST, RD_CMD);
  - the grant enum (GNT_WR, GNT_RD);
  - the `MAX_LOCAL_SIZE`=4 constant.
- One sub-module, `ddr2_local_rd_tracker`, holds the outstanding-beat counter, the credit check and the registered read-return path.

## Test plan
- Write size 4 at address `0x0000100` with `local_ready` high → burstbegin only on beat 1, four `wr_ack` pulses, return to IDLE.
- Read size 4 followed by read size 4 with no returns and `MAX_RD_BEATS`=8 → both accepted. A third `rd_req` is blocked until the first `local_rdata_valid`.
- `wr_req` and `rd_req` together repeatedly → grants alternate W,R,W,R. With `DDR2_LOCAL_ARB_RD_PRIO_EN` → R always wins.
- `local_ready` low for 3 cycles during beat 2 of a size-3 write → beat 2 data is held, `wr_ack` stays low, burstbegin is not reasserted.
- Read acceptance and `local_rdata_valid` in the same cycle with `rd_out`=2, size 2 → `rd_out`=3.
- `reset` asserted mid-write → all outputs 0 immediately and FSM in IDLE. `local_init_done` low after reset → no grant issued.
